// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared constants and one-hot FSM encoding for the Wishbone round-robin arbiter
package wb_arb_pkg;
   localparam int IDLE = 0;
   localparam int OWN = 1;
   localparam int ABORT = 2;
   localparam int SEL_W = 4;
   localparam int DEF_TIMEOUT = 255;
   typedef enum logic [2:0] {
      ST_IDLE = 3'(1 << IDLE),
      ST_OWN = 3'(1 << OWN),
      ST_ABORT = 3'(1 << ABORT)
   } state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot pick of the first requester at or after ptr, wrapping modulo N
module rr_pick #(
   parameter int N = 4,
   parameter int PW = 2
) (
   input logic [N-1:0] req,
   input logic [PW-1:0] ptr,
   output logic [N-1:0] grant,
   output logic found
);
   logic [N-1:0] rot, iso;
   always_comb begin
      rot = (req >> ptr) | (req << (N - int'(ptr)));
      iso = rot & (~rot + N'(1));
      grant = (iso << ptr) | (iso >> (N - int'(ptr)));
      found = |req;
   end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, owner holds the bus while cyc is high, stalled strobes abort with err
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int ADR_W = 36,
   parameter int DAT_W = 32,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic clk,
   input logic nrst,
   input logic [NUM_MASTERS*ADR_W-1:0] m_adr_i,
   input logic [NUM_MASTERS*DAT_W-1:0] m_dat_i,
   input logic [NUM_MASTERS*SEL_W-1:0] m_sel_i,
   input logic [NUM_MASTERS-1:0] m_we_i,
   input logic [NUM_MASTERS-1:0] m_stb_i,
   input logic [NUM_MASTERS-1:0] m_cyc_i,
   output logic [DAT_W-1:0] m_dat_o,
   output logic [NUM_MASTERS-1:0] m_ack_o,
   output logic [NUM_MASTERS-1:0] m_err_o,
   output logic [ADR_W-1:0] s_adr_o,
   output logic [DAT_W-1:0] s_dat_o,
   output logic [SEL_W-1:0] s_sel_o,
   output logic s_we_o,
   output logic s_stb_o,
   output logic s_cyc_o,
   input logic [DAT_W-1:0] s_dat_i,
   input logic s_ack_i,
   output logic [NUM_MASTERS-1:0] grant_o,
   output logic timeout_o
);
   localparam int PW = $clog2(NUM_MASTERS);
   state_t state;
   logic [PW-1:0] ptr, gidx, nxt_ptr;
   logic [7:0] wd;
   logic [NUM_MASTERS-1:0] pick;
   logic found, own, cyc_g, stb_g, we_g, stall;
   rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_pick (
      .req(m_cyc_i),
      .ptr(ptr),
      .grant(pick),
      .found(found)
   );
   always_comb begin
      cyc_g = 1'b0;
      stb_g = 1'b0;
      we_g = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      gidx = '0;
      for (int k = 0; k < NUM_MASTERS; k++)
         if (grant_o[k]) begin
            cyc_g = m_cyc_i[k];
            stb_g = m_stb_i[k];
            we_g = m_we_i[k];
            s_adr_o = m_adr_i[k*ADR_W +: ADR_W];
            s_dat_o = m_dat_i[k*DAT_W +: DAT_W];
            s_sel_o = m_sel_i[k*SEL_W +: SEL_W];
            gidx = PW'(k);
         end
   end
   assign own = state == ST_OWN;
   assign s_cyc_o = own & cyc_g;
   assign s_stb_o = own & stb_g;
   assign s_we_o = own & we_g;
   assign stall = s_stb_o & ~s_ack_i;
   assign m_dat_o = s_dat_i;
   assign m_ack_o = (own && s_ack_i) ? grant_o : '0;
   assign m_err_o = (state == ST_ABORT) ? grant_o : '0;
   assign timeout_o = state == ST_ABORT;
   assign nxt_ptr = (gidx == PW'(NUM_MASTERS - 1)) ? '0 : gidx + PW'(1);
   // an ack on the last permitted stalled cycle wins because stall already excludes it
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state <= ST_IDLE;
         grant_o <= '0;
         ptr <= '0;
         wd <= '0;
      end else if (state == ST_IDLE) begin
         wd <= '0;
         if (found) begin
            grant_o <= pick;
            state <= ST_OWN;
         end
      end else if (state == ST_OWN) begin
         if (!cyc_g) begin
            grant_o <= '0;
            ptr <= nxt_ptr;
            wd <= '0;
            state <= ST_IDLE;
         end else if (stall && wd == 8'(TIMEOUT - 1)) begin
            wd <= '0;
            state <= ST_ABORT;
         end else
            wd <= stall ? wd + 8'd1 : '0;
      end else begin
         grant_o <= '0;
         ptr <= nxt_ptr;
         state <= ST_IDLE;
      end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed and random stimulus against an integer-level arbitration model
module tb_wb_rr_arbiter;
   localparam int N = 4, AW = 36, DW = 32, SW = 4, TO = 8;
   logic clk = 1'b0, nrst = 1'b0;
   logic [N*AW-1:0] m_adr = '0;
   logic [N*DW-1:0] m_dat = '0;
   logic [N*SW-1:0] m_sel = '0;
   logic [N-1:0] m_we = '0, m_stb = '0, m_cyc = '0;
   logic [DW-1:0] s_dat = '0, m_dat_o, s_dat_o;
   logic [N-1:0] m_ack_o, m_err_o, grant_o;
   logic [AW-1:0] s_adr_o;
   logic [SW-1:0] s_sel_o;
   logic s_ack = 1'b0, s_we_o, s_stb_o, s_cyc_o, timeout_o;
   int nvec = 0, nbad = 0;
   int m_own = -1, m_ptr = 0, m_wd = 0;
   bit m_abt = 1'b0;
   always #5 clk = ~clk;
   wb_rr_arbiter #(.NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .nrst(nrst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_stb_i(m_stb), .m_cyc_i(m_cyc),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic set_m(input int k, input logic c, input logic s, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] sl);
      m_cyc[k] = c;
      m_stb[k] = s;
      m_we[k] = w;
      m_adr[k*AW +: AW] = a;
      m_dat[k*DW +: DW] = d;
      m_sel[k*SW +: SW] = sl;
   endtask
   task automatic mdl_reset();
      m_own = -1;
      m_ptr = 0;
      m_wd = 0;
      m_abt = 1'b0;
   endtask
   // bus rules: owner keeps bus while cyc is held, TO consecutive unacked strobes abort
   task automatic mdl_step();
      if (m_abt) begin
         m_ptr = (m_own + 1) % N;
         m_own = -1;
         m_abt = 1'b0;
      end else if (m_own >= 0) begin
         if (!m_cyc[m_own]) begin
            m_ptr = (m_own + 1) % N;
            m_own = -1;
            m_wd = 0;
         end else if (m_stb[m_own] && !s_ack) begin
            m_wd++;
            if (m_wd == TO) begin
               m_abt = 1'b1;
               m_wd = 0;
            end
         end else
            m_wd = 0;
      end else
         for (int k = 0; k < N; k++)
            if (m_own < 0 && m_cyc[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
   endtask
   task automatic check_outs();
      logic [N-1:0] eg;
      logic on, ec, es, ew;
      eg = (m_own >= 0) ? N'(1) << m_own : '0;
      on = (m_own >= 0) && !m_abt;
      ec = 1'b0;
      es = 1'b0;
      ew = 1'b0;
      if (on) begin
         ec = m_cyc[m_own];
         es = m_stb[m_own];
         ew = m_we[m_own];
         chk("s_adr", 64'(s_adr_o), 64'(m_adr[m_own*AW +: AW]));
         chk("s_dat", 64'(s_dat_o), 64'(m_dat[m_own*DW +: DW]));
         chk("s_sel", 64'(s_sel_o), 64'(m_sel[m_own*SW +: SW]));
      end
      chk("grant", 64'(grant_o), 64'(eg));
      chk("s_cyc", 64'(s_cyc_o), 64'(ec));
      chk("s_stb", 64'(s_stb_o), 64'(es));
      chk("s_we", 64'(s_we_o), 64'(ew));
      chk("m_ack", 64'(m_ack_o), 64'((on && s_ack) ? eg : '0));
      chk("m_err", 64'(m_err_o), 64'(m_abt ? eg : '0));
      chk("timeout", 64'(timeout_o), 64'(m_abt));
      chk("m_dat", 64'(m_dat_o), 64'(s_dat));
   endtask
   task automatic tick();
      #1 check_outs();
      @(posedge clk);
      if (nrst) mdl_step();
      @(negedge clk);
   endtask
   task automatic do_reset();
      nrst = 1'b0;
      m_cyc = '0;
      m_stb = '0;
      s_ack = 1'b0;
      mdl_reset();
      tick();
      tick();
      nrst = 1'b1;
   endtask
   initial begin
      @(negedge clk);
      do_reset();
      // single requester read with slave ack on its third owned cycle
      set_m(1, 1'b1, 1'b1, 1'b0, 36'h0_0000_1000, '0, 4'hF);
      tick();
      #1 chk("t1_cyc_up", 64'(s_cyc_o), 64'(1));
      chk("t1_grant", 64'(grant_o), 64'(4'b0010));
      tick();
      tick();
      s_ack = 1'b1;
      s_dat = 32'hDEADBEEF;
      #1 chk("t1_ack", 64'(m_ack_o), 64'(4'b0010));
      chk("t1_rdata", 64'(m_dat_o), 64'(32'hDEADBEEF));
      tick();
      s_ack = 1'b0;
      set_m(1, 1'b0, 1'b0, 1'b0, 36'h0_0000_1000, '0, 4'hF);
      #1 chk("t1_ack_once", 64'(m_ack_o), 64'(0));
      tick();
      tick();
      // everyone requesting: rotation 0,1,2,3,0 with one idle clock between owners
      do_reset();
      for (int k = 0; k < N; k++) set_m(k, 1'b1, 1'b1, 1'b0, AW'(k * 16), DW'(k), 4'hF);
      tick();
      for (int i = 0; i < 5; i++) begin
         #1 chk("t2_grant", 64'(grant_o), 64'(4'b0001 << (i % N)));
         s_ack = 1'b1;
         tick();
         s_ack = 1'b0;
         m_cyc[i % N] = 1'b0;
         m_stb[i % N] = 1'b0;
         tick();
         #1 chk("t2_idle", 64'(grant_o), 64'(0));
         m_cyc[i % N] = 1'b1;
         m_stb[i % N] = 1'b1;
         tick();
      end
      m_cyc = '0;
      m_stb = '0;
      tick();
      tick();
      // master 2 locks the bus across three writes while master 0 waits
      set_m(2, 1'b1, 1'b1, 1'b1, 36'h2_0000_0040, 32'd1, 4'hF);
      tick();
      set_m(0, 1'b1, 1'b1, 1'b0, 36'h0_0000_0080, 32'd99, 4'h3);
      for (int w = 1; w <= 3; w++) begin
         m_dat[2*DW +: DW] = DW'(w);
         m_stb[2] = 1'b1;
         s_ack = 1'b1;
         #1 chk("t3_wdata", 64'(s_dat_o), 64'(w));
         chk("t3_we", 64'(s_we_o), 64'(1));
         chk("t3_ack2", 64'(m_ack_o), 64'(4'b0100));
         tick();
         m_stb[2] = 1'b0;
         s_ack = 1'b0;
         #1 chk("t3_m0_wait", 64'(m_ack_o[0]), 64'(0));
         tick();
      end
      m_cyc[2] = 1'b0;
      tick();
      tick();
      #1 chk("t3_m0_grant", 64'(grant_o), 64'(4'b0001));
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      tick();
      tick();
      // master 3 never acknowledged: abort after TO stalled strobes
      set_m(3, 1'b1, 1'b1, 1'b0, 36'h3_0000_0000, '0, 4'hF);
      tick();
      for (int c = 0; c < TO; c++) tick();
      #1 chk("t4_err", 64'(m_err_o), 64'(4'b1000));
      chk("t4_timeout", 64'(timeout_o), 64'(1));
      chk("t4_cyc_low", 64'(s_cyc_o), 64'(0));
      tick();
      #1 chk("t4_grant_clr", 64'(grant_o), 64'(0));
      chk("t4_pulse", 64'(timeout_o), 64'(0));
      m_cyc[3] = 1'b0;
      m_stb[3] = 1'b0;
      tick();
      tick();
      // ack on the last permitted cycle completes normally
      set_m(3, 1'b1, 1'b1, 1'b0, 36'h3_0000_0004, '0, 4'hF);
      tick();
      for (int c = 0; c < TO - 1; c++) tick();
      s_ack = 1'b1;
      #1 chk("t5_ack", 64'(m_ack_o), 64'(4'b1000));
      chk("t5_no_err", 64'(m_err_o), 64'(0));
      tick();
      s_ack = 1'b0;
      m_cyc[3] = 1'b0;
      m_stb[3] = 1'b0;
      #1 chk("t5_no_timeout", 64'(timeout_o), 64'(0));
      tick();
      tick();
      // async reset while master 1 owns; pointer must return to 0
      set_m(0, 1'b1, 1'b1, 1'b0, 36'h0, '0, 4'hF);
      tick();
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      tick();
      tick();
      set_m(1, 1'b1, 1'b1, 1'b1, 36'h1_2345_6789, 32'h5555_AAAA, 4'hC);
      tick();
      #1 chk("t6_owner1", 64'(grant_o), 64'(4'b0010));
      #1 nrst = 1'b0;
      mdl_reset();
      #1 chk("t6_cyc_drop", 64'(s_cyc_o), 64'(0));
      chk("t6_stb_drop", 64'(s_stb_o), 64'(0));
      chk("t6_grant_drop", 64'(grant_o), 64'(0));
      set_m(0, 1'b1, 1'b1, 1'b0, 36'h0, '0, 4'hF);
      #4 nrst = 1'b1;
      @(negedge clk);
      tick();
      #1 chk("t6_m0_wins", 64'(grant_o), 64'(4'b0001));
      m_cyc = '0;
      m_stb = '0;
      tick();
      tick();
      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N; k++)
            if (!m_cyc[k]) begin
               if ($urandom_range(9, 0) < 3)
                  set_m(k, 1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                        AW'({$urandom, $urandom}), DW'($urandom), SW'($urandom));
            end else if ($urandom_range(9, 0) < 1) begin
               m_cyc[k] = 1'b0;
               m_stb[k] = 1'b0;
            end else begin
               m_stb[k] = $urandom_range(9, 0) < 7;
               m_dat[k*DW +: DW] = DW'($urandom);
            end
         s_ack = $urandom_range(99, 0) < ((c < 300) ? 40 : 8);
         s_dat = DW'($urandom);
         tick();
      end
      m_cyc = '0;
      m_stb = '0;
      s_ack = 1'b0;
      tick();
      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone slave port between up to NUM_MASTERS Wishbone masters, for example the LIMB bridge, a DMA engine and the CPU bridge.
- Arbitration is round-robin. A granted master keeps the bus for as long as it holds cyc, which supports locked and multi-beat sequences.
- A watchdog aborts any strobe the slave never acknowledges and returns err to the master.
- Sits between the master-side bridges and the northbridge address decoder.

Parameters:
- NUM_MASTERS, 4: number of requesters, 2..8.
- ADR_W, 36: Wishbone address width.
- DAT_W, 32: Wishbone data width.
- TIMEOUT, 255: cycles of stb without ack before abort, 1..255.

Ports:
- clk  in  1  sole clock.
- nrst  in  1  asynchronous active-low reset.
- m_adr_i  in  NUM_MASTERS*ADR_W  master addresses; master k occupies slice [k*ADR_W +: ADR_W].
- m_dat_i  in  NUM_MASTERS*DAT_W  master write data.
- m_sel_i  in  NUM_MASTERS*4  byte selects.
- m_we_i  in  NUM_MASTERS  write enables.
- m_stb_i  in  NUM_MASTERS  strobes.
- m_cyc_i  in  NUM_MASTERS  cycle requests.
- m_dat_o  out  DAT_W  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  ack, routed to the granted master only.
- m_err_o  out  NUM_MASTERS  timeout error, routed to the granted master only.
- s_adr_o  out  ADR_W  slave address.
- s_dat_o  out  DAT_W  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_stb_o  out  1  slave strobe.
- s_cyc_o  out  1  slave cycle.
- s_dat_i  in  DAT_W  slave read data.
- s_ack_i  in  1  slave ack.
- grant_o  out  NUM_MASTERS  one-hot current grant; 0 when idle.
- timeout_o  out  1  one-cycle pulse on each abort.

Behaviour:
- Reset (nrst low, asynchronous): state IDLE, grant_o=0, priority pointer=0, watchdog=0, timeout_o=0. All s_* control outputs and all m_ack_o/m_err_o are 0 while reset is asserted.
- States: IDLE, OWN, ABORT. State encoding is one-hot.
- IDLE:
  - If any m_cyc_i is high, pick the first requester at or after the pointer, wrapping modulo NUM_MASTERS.
  - Register that pick in grant_o and go to OWN.
  - Arbitration latency: 1 clk from cyc to s_cyc_o.
- OWN:
  - Combinational mux from the granted master: s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o = master values.
  - m_ack_o[g] = s_ack_i. Every other master's ack and err are 0.
  - Non-granted masters see no ack and wait.
  - When m_cyc_i[g] falls: grant_o <= 0, pointer <= g+1 modulo NUM_MASTERS, go to IDLE. One dead cycle on s_cyc_o is guaranteed between owners.
- Watchdog:
  - In OWN, counts cycles where s_stb_o=1 and s_ack_i=0.
  - Clears on s_ack_i or when stb is low.
  - When it reaches TIMEOUT: go to ABORT.
- ABORT (one cycle):
  - s_cyc_o=0, s_stb_o=0, m_err_o[g]=1, timeout_o=1.
  - Then grant_o <= 0, pointer <= g+1, go to IDLE, even if the master still holds cyc.
  - A master still holding cyc re-competes in normal rotation.
- Simultaneous events:
  - s_ack_i arriving on the TIMEOUT-th cycle counts as ack. No abort.
  - A master dropping cyc in the same cycle as its ack completes normally.
  - With all masters requesting, grants rotate 0,1,2,3,0.
- Asynchronous reset mid-cycle drops s_cyc_o immediately.
- The slave is expected to ignore an unterminated cycle once s_cyc_o falls.

Decomposition:
- Package wb_arb_pkg holds:
  - state index localparams IDLE/OWN/ABORT;
  - the SEL_W=4 constant;
  - the default TIMEOUT.
- Sub-module rr_pick (purely combinational):
  - inputs: req vector and pointer;
  - outputs: one-hot grant and a found flag;
  - method: rotate, priority-encode, rotate back.
- The FSM, watchdog and muxes stay in wb_rr_arbiter.

Test Plan:
- Reset, then only master 1 asserts cyc/stb with adr=36'h0_0000_1000 and we=0; slave acks with 32'hDEADBEEF after 3 clks.
  - Required: s_cyc_o rises 1 clk after cyc, grant_o=4'b0010, m_dat_o=DEADBEEF, m_ack_o=4'b0010 for exactly 1 clk.
- All four masters hold cyc continuously, and each drops cyc 1 clk after its ack.
  - Required: grant order 0,1,2,3,0, with one idle clk between grants.
- Master 2 holds cyc across 3 stb/ack writes (dat 1,2,3) while master 0 requests.
  - Required: master 0 receives no ack until master 2 drops cyc, and the slave sees all 3 writes from master 2 uninterrupted.
- TIMEOUT=8 and the slave never acks master 3.
  - Required: on clk 8 of stb, m_err_o=4'b1000 and timeout_o=1 for 1 clk, s_cyc_o=0, grant_o=0 next clk.
- TIMEOUT=8 with ack on stb cycle 8.
  - Required: normal ack, no err, no timeout_o.
- nrst pulsed low for half a clk while master 1 owns the bus.
  - Required: s_cyc_o, s_stb_o and grant_o drop asynchronously, and after release master 0 wins when both 0 and 1 request.
